// File: rtl/pipeline_feeder.sv
`default_nettype none
// ============================================================================
// pipeline_feeder : issues bots into a slot ring, drains on flush and reads
//                   every occupied slot back, checking collector counts.
// Revision        : 1.0
// ============================================================================
module pipeline_feeder #(
  parameter int ADDR_WIDTH     = 9,
  parameter int FULLNESS_LIMIT = 20,
  parameter int READ_LATENCY   = 3,
  parameter int DRAIN_CYCLES   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_bot,
  input  logic [5:0]            in_perms,
  input  logic                  flush,
  output logic [127:0]          bot,
  output logic [ADDR_WIDTH-1:0] botIndex,
  output logic                  isBotValid,
  output logic [5:0]            validBotPermutations,
  input  logic [4:0]            fifoFullness,
  input  logic [37:0]           summedData,
  input  logic [2:0]            pcoeffCount,
  output logic                  res_valid,
  output logic [37:0]           res_sum,
  output logic [ADDR_WIDTH-1:0] res_index,
  output logic [2:0]            res_pcoeff,
  output logic                  count_error,
  output logic                  flush_done
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, READOUT = 2'd2, DONE = 2'd3} state_t;

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] OCC_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam int                  DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [31:0]         LIMIT_U  = FULLNESS_LIMIT;

  state_t                r_state, w_nextState;
  logic [ADDR_WIDTH-1:0] r_wrIdx;
  logic [ADDR_WIDTH:0]   r_occ;
  logic [DRAIN_W-1:0]    r_drainCnt;
  logic [5:0]            r_maskRam [DEPTH];

  logic                  w_handshake, w_roIssue, w_resGen, w_inFlight;
  logic [ADDR_WIDTH-1:0] w_issueIdx;
  logic [2:0]            w_expCount;

  // Result tag travels alongside the issue, then through the read-latency line.
  logic                    r_pendValid;
  logic [ADDR_WIDTH-1:0]   r_pendIdx;
  logic [2:0]              r_pendExp;
  logic [READ_LATENCY-1:0] r_dlValid;
  logic [ADDR_WIDTH-1:0]   r_dlIdx [READ_LATENCY];
  logic [2:0]              r_dlExp [READ_LATENCY];

  function automatic logic [2:0] popCount6(input logic [5:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]) + 3'(m[4]) + 3'(m[5]);
  endfunction

  assign w_handshake = in_valid && in_ready;
  assign w_roIssue   = (r_state == READOUT) && (r_occ != '0);
  assign w_issueIdx  = w_roIssue ? (r_wrIdx - r_occ[ADDR_WIDTH-1:0]) : r_wrIdx;
  assign w_expCount  = popCount6(r_maskRam[w_issueIdx]);
  assign w_resGen    = w_roIssue || (w_handshake && (r_occ == OCC_FULL));
  assign w_inFlight  = r_pendValid || (|r_dlValid);

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    flush_done  = 1'b0;
    case (r_state)
      RUN: begin
        in_ready = !flush && ({27'd0, fifoFullness} < LIMIT_U);
        if (flush) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (r_occ == '0)
          w_nextState = DONE;
        else if ((fifoFullness == '0) && (r_drainCnt == DRAIN_W'(DRAIN_CYCLES - 1)))
          w_nextState = READOUT;
      end
      READOUT: begin
        if ((r_occ == '0) && !w_inFlight) w_nextState = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        if (!flush) w_nextState = RUN;
      end
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wrIdx    <= '0;
      r_occ      <= '0;
      r_drainCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_handshake) begin
        r_wrIdx <= r_wrIdx + ADDR_WIDTH'(1);
        if (r_occ != OCC_FULL) r_occ <= r_occ + (ADDR_WIDTH + 1)'(1);
      end else if (w_roIssue) begin
        r_occ <= r_occ - (ADDR_WIDTH + 1)'(1);
      end
      if ((r_state == DRAIN) && (fifoFullness == '0))
        r_drainCnt <= r_drainCnt + DRAIN_W'(1);
      else
        r_drainCnt <= '0;
    end
  end

  // Mask RAM holds contents across reset; only the occupancy tracking is cleared.
  always_ff @(posedge clk) begin
    if (w_handshake) r_maskRam[r_wrIdx] <= in_perms;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isBotValid           <= 1'b0;
      botIndex             <= '0;
      bot                  <= '0;
      validBotPermutations <= '0;
      r_pendValid          <= 1'b0;
      r_pendIdx            <= '0;
      r_pendExp            <= '0;
      r_dlValid            <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_dlIdx[i] <= '0;
        r_dlExp[i] <= '0;
      end
      res_valid   <= 1'b0;
      res_sum     <= '0;
      res_index   <= '0;
      res_pcoeff  <= '0;
      count_error <= 1'b0;
    end else begin
      isBotValid <= w_handshake || w_roIssue;
      if (w_handshake) begin
        bot                  <= in_bot;
        validBotPermutations <= in_perms;
        botIndex             <= r_wrIdx;
      end else if (w_roIssue) begin
        bot                  <= '0;
        validBotPermutations <= '0;
        botIndex             <= w_issueIdx;
      end

      r_pendValid  <= w_resGen;
      r_pendIdx    <= w_issueIdx;
      r_pendExp    <= w_expCount;
      r_dlValid[0] <= r_pendValid;
      r_dlIdx[0]   <= r_pendIdx;
      r_dlExp[0]   <= r_pendExp;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_dlValid[i] <= r_dlValid[i-1];
        r_dlIdx[i]   <= r_dlIdx[i-1];
        r_dlExp[i]   <= r_dlExp[i-1];
      end

      res_valid <= r_dlValid[READ_LATENCY-1];
      if (r_dlValid[READ_LATENCY-1]) begin
        res_sum    <= summedData;
        res_index  <= r_dlIdx[READ_LATENCY-1];
        res_pcoeff <= pcoeffCount;
        if (pcoeffCount != r_dlExp[READ_LATENCY-1]) count_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_feeder.sv
`default_nettype none
// Bench for pipeline_feeder: directed vectors, queue scoreboard, small collector model.
module tb_pipeline_feeder;
  localparam int AW = 2;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_bot = '0;
  logic [5:0]    in_perms = '0;
  logic          flush = 1'b0;
  logic [127:0]  bot;
  logic [AW-1:0] botIndex;
  logic          isBotValid;
  logic [5:0]    validBotPermutations;
  logic [4:0]    fifoFullness = '0;
  logic [37:0]   summedData;
  logic [2:0]    pcoeffCount;
  logic          res_valid;
  logic [37:0]   res_sum;
  logic [AW-1:0] res_index;
  logic [2:0]    res_pcoeff;
  logic          count_error;
  logic          flush_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {logic [AW-1:0] idx; logic [5:0] perms; logic [127:0] b;} issue_t;
  typedef struct {logic [AW-1:0] idx; logic [37:0] sum; logic [2:0] pc; int at;} res_t;
  issue_t issueQ[$];
  res_t   resQ[$];

  pipeline_feeder #(
    .ADDR_WIDTH(AW), .FULLNESS_LIMIT(20), .READ_LATENCY(RL), .DRAIN_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bot(in_bot), .in_perms(in_perms), .flush(flush), .bot(bot),
    .botIndex(botIndex), .isBotValid(isBotValid),
    .validBotPermutations(validBotPermutations), .fifoFullness(fifoFullness),
    .summedData(summedData), .pcoeffCount(pcoeffCount), .res_valid(res_valid),
    .res_sum(res_sum), .res_index(res_index), .res_pcoeff(res_pcoeff),
    .count_error(count_error), .flush_done(flush_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collector: returns 0x1000+slot as the sum and a programmable count per slot.
  bit            cV0, cV1, cV2;
  logic [AW-1:0] cI0, cI1, cI2;
  logic [2:0]    slotCnt [4];
  always @(posedge clk) begin
    cV0 <= isBotValid; cI0 <= botIndex;
    cV1 <= cV0;        cI1 <= cI0;
    cV2 <= cV1;        cI2 <= cI1;
  end
  assign summedData  = cV2 ? (38'h1000 + 38'(cI2)) : 38'h0;
  assign pcoeffCount = cV2 ? slotCnt[cI2] : 3'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (isBotValid) begin
        if (issueQ.size() == 0) chk("unexpected_issue", isBotValid, 1'b0);
        else begin
          issue_t e;
          e = issueQ.pop_front();
          chk("botIndex", botIndex, e.idx);
          chk("validBotPermutations", validBotPermutations, e.perms);
          chk("bot", bot, e.b);
        end
      end
      if (res_valid) begin
        if (resQ.size() == 0) chk("unexpected_result", res_valid, 1'b0);
        else begin
          res_t r;
          r = resQ.pop_front();
          chk("res_index", res_index, r.idx);
          chk("res_sum", res_sum, r.sum);
          chk("res_pcoeff", res_pcoeff, r.pc);
          chk("res_cycle", cyc, r.at);
        end
      end
    end
  end

  task automatic sendBot(input logic [127:0] b, input logic [5:0] p, input logic [AW-1:0] expIdx,
                         input bit expRes, input logic [2:0] resPc);
    @(negedge clk);
    in_valid = 1'b1; in_bot = b; in_perms = p;
    #1 chk("in_ready", in_ready, 1'b1);
    issueQ.push_back('{expIdx, p, b});
    if (expRes) resQ.push_back('{expIdx, 38'h1000 + 38'(expIdx), resPc, cyc + 5});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!flush_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_flush_done"}, flush_done, 1'b1);
    chk({tag, "_results_left"}, resQ.size(), 0);
    chk({tag, "_issues_left"}, issueQ.size(), 0);
    flush = 1'b0;
    @(negedge clk);
    chk({tag, "_back_to_run_ready"}, in_ready, 1'b1);
    chk({tag, "_done_cleared"}, flush_done, 1'b0);
  endtask

  initial begin
    int f;
    int n;
    int seen;
    slotCnt = '{3'd3, 3'd2, 3'd0, 3'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_isBotValid", isBotValid, 1'b0);
    chk("rst_botIndex", botIndex, 0);
    chk("rst_bot", bot, 0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_count_error", count_error, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Fill the 4-slot ring, then wrap: slot 0 displaced (mask 000111 -> 3).
    sendBot(128'hF000_0000_0000_0000_0000_0000_0000_0001, 6'b000111, 2'd0, 1'b0, 3'd0);
    sendBot(128'h0000_0000_AAAA_5555_0000_0000_0000_0002, 6'b101010, 2'd1, 1'b0, 3'd0);
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0003, 6'b000000, 2'd2, 1'b0, 3'd0);
    sendBot(128'h8000_0000_0000_0000_0000_0000_0000_0004, 6'b111111, 2'd3, 1'b0, 3'd0);
    sendBot(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 6'b110000, 2'd0, 1'b1, 3'd3);
    repeat (8) @(negedge clk);
    chk("count_error_match", count_error, 1'b0);
    // Slot 1 held 101010 (3) but the collector reports 2.
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0006, 6'b001100, 2'd1, 1'b1, 3'd2);
    repeat (8) @(negedge clk);
    chk("count_error_set", count_error, 1'b1);

    @(negedge clk);
    fifoFullness = 5'd19;
    #1 chk("ready_at_19", in_ready, 1'b1);
    fifoFullness = 5'd20; in_valid = 1'b1; in_bot = 128'hDEAD; in_perms = 6'b000001;
    #1 chk("ready_at_20", in_ready, 1'b0);
    @(negedge clk);
    chk("no_issue_at_20", isBotValid, 1'b0);
    in_valid = 1'b0; fifoFullness = '0;
    chk("count_error_sticky", count_error, 1'b1);

    // Full ring flush: wr_idx=2, occ=4 -> readout 2,3,0,1.
    slotCnt = '{3'd2, 3'd2, 3'd0, 3'd6};
    @(negedge clk);
    flush = 1'b1; f = cyc;
    issueQ.push_back('{2'd2, 6'd0, 128'h0});
    issueQ.push_back('{2'd3, 6'd0, 128'h0});
    issueQ.push_back('{2'd0, 6'd0, 128'h0});
    issueQ.push_back('{2'd1, 6'd0, 128'h0});
    resQ.push_back('{2'd2, 38'h1002, 3'd0, f + 70});
    resQ.push_back('{2'd3, 38'h1003, 3'd6, f + 71});
    resQ.push_back('{2'd0, 38'h1000, 3'd2, f + 72});
    resQ.push_back('{2'd1, 38'h1001, 3'd2, f + 73});
    waitDone("flush4");

    // Three bots after the first flush: slots 2,3,0, read back oldest first.
    slotCnt = '{3'd4, 3'd0, 3'd1, 3'd2};
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0011, 6'b000001, 2'd2, 1'b0, 3'd0);
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0012, 6'b011000, 2'd3, 1'b0, 3'd0);
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0013, 6'b111100, 2'd0, 1'b0, 3'd0);
    @(negedge clk);
    flush = 1'b1; f = cyc;
    issueQ.push_back('{2'd2, 6'd0, 128'h0});
    issueQ.push_back('{2'd3, 6'd0, 128'h0});
    issueQ.push_back('{2'd0, 6'd0, 128'h0});
    resQ.push_back('{2'd2, 38'h1002, 3'd1, f + 70});
    resQ.push_back('{2'd3, 38'h1003, 3'd2, f + 71});
    resQ.push_back('{2'd0, 38'h1000, 3'd4, f + 72});
    waitDone("flush3");

    // Reset in the middle of a readout.
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0021, 6'b000011, 2'd1, 1'b0, 3'd0);
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0022, 6'b000101, 2'd2, 1'b0, 3'd0);
    @(negedge clk);
    flush = 1'b1;
    issueQ.push_back('{2'd1, 6'd0, 128'h0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!isBotValid && n < 200);
    chk("readout_started", isBotValid, 1'b1);
    #2 rst_n = 1'b0; flush = 1'b0;
    issueQ.delete(); resQ.delete();
    #1;
    chk("rro_isBotValid", isBotValid, 1'b0);
    chk("rro_botIndex", botIndex, 0);
    chk("rro_bot", bot, 0);
    chk("rro_perms", validBotPermutations, 0);
    chk("rro_res_valid", res_valid, 1'b0);
    chk("rro_res_sum", res_sum, 0);
    chk("rro_res_index", res_index, 0);
    chk("rro_res_pcoeff", res_pcoeff, 0);
    chk("rro_count_error", count_error, 1'b0);
    chk("rro_flush_done", flush_done, 1'b0);
    chk("rro_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid || isBotValid) seen++;
    end
    chk("no_stale_activity", seen, 0);
    sendBot(128'h0000_0000_0000_0000_0000_0000_0000_0031, 6'b000001, 2'd0, 1'b0, 3'd0);
    repeat (8) @(negedge clk);
    chk("final_issues_left", issueQ.size(), 0);
    chk("final_results_left", resQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
